wb_uart: RTL

//  Wishbone pipelined slave UART (8N1) for the J1 data bus; 16-bit registers.

---
 rtl/wb_uart_pkg.sv | 24 ++
 rtl/wb_uart_if.sv | 22 ++
 rtl/wb_uart_fifo.sv | 39 +++
 rtl/wb_uart.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_uart_pkg.sv
// wb_uart shared definitions: register offsets, STAT bit
// indices and the TX/RX state encodings.
package wb_uart_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;
  localparam logic [1:0] REG_RSVD = 2'd3;

  localparam int STAT_RXV = 0;
  localparam int STAT_TXR = 1;
  localparam int STAT_TXB = 2;
  localparam int STAT_OVR = 3;
  localparam int STAT_FRM = 4;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

endpackage

// File: rtl/wb_uart_if.sv
// Wishbone pipelined bus bundle, 16-bit data.
// master drives adr/cyc/stb/we/dat_i; slave drives dat_o/ack/stall.
interface wb_uart_if;
  logic [15:0] adr;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] dat_i;
  logic [15:0] dat_o;
  logic        ack;
  logic        stall;

  modport master (
    output adr, cyc, stb, we, dat_i,
    input  dat_o, ack, stall
  );

  modport slave (
    input  adr, cyc, stb, we, dat_i,
    output dat_o, ack, stall
  );
endinterface

// File: rtl/wb_uart_fifo.sv
// Byte-wide synchronous FIFO for RX storage.
// Ports: clk, rst_n, push, pop, din, dout, empty, full.
module wb_uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  assign empty = wptr == rptr;
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/wb_uart.sv
// Wishbone pipelined slave UART (8N1), 16-bit registers.
// Ports: clk, rst_n, wb (slave), rxd, txd, irq. Macro WB_UART_RX_FIFO_EN.
module wb_uart
  import wb_uart_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = 16'd434,
  parameter int          RX_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_uart_if.slave   wb,
  input  logic       rxd,
  output logic       txd,
  output logic       irq
);
  logic        acc, rd, wr;
  logic [1:0]  sel;
  logic        ack_q;
  logic [15:0] dat_q, rdata;
  logic [15:0] div_q;

  assign acc      = wb.cyc & wb.stb;
  assign rd       = acc & ~wb.we;
  assign wr       = acc & wb.we;
  assign sel      = wb.adr[2:1];
  assign wb.stall = 1'b0;
  assign wb.ack   = ack_q;
  assign wb.dat_o = dat_q;

  wire unused = &{1'b0, wb.adr[15:3], wb.adr[0]};

  // ---------------- TX ----------------
  tx_state_t   tx_st, tx_d;
  logic [15:0] tx_cnt, tx_cnt_d;
  logic [2:0]  tx_bit, tx_bit_d;
  logic [7:0]  tx_sh, tx_sh_d;
  logic        txd_q, txd_d;
  logic [7:0]  hold_q;
  logic        hold_full, take_hold;
  logic        tx_ready, tx_busy, tx_wr;

  // holding reg frees up in the same cycle it is moved
  assign tx_ready = ~hold_full | take_hold;
  assign tx_busy  = hold_full | (tx_st != TX_IDLE);
  assign tx_wr    = wr & (sel == REG_DATA) & tx_ready;
  assign txd      = txd_q;

  always_comb begin
    tx_d      = tx_st;
    tx_cnt_d  = tx_cnt;
    tx_bit_d  = tx_bit;
    tx_sh_d   = tx_sh;
    txd_d     = txd_q;
    take_hold = 1'b0;
    if (tx_st != TX_IDLE && tx_cnt != 16'd0)
      tx_cnt_d = tx_cnt - 16'd1;
    unique case (tx_st)
      TX_IDLE: if (hold_full) begin
        take_hold = 1'b1;
        tx_d      = TX_START;
        tx_sh_d   = hold_q;
        txd_d     = 1'b0;
        tx_cnt_d  = div_q - 16'd1;
      end
      TX_START: if (tx_cnt == 16'd0) begin
        tx_d     = TX_DATA;
        tx_bit_d = 3'd0;
        txd_d    = tx_sh[0];
        tx_cnt_d = div_q - 16'd1;
      end
      TX_DATA: if (tx_cnt == 16'd0) begin
        tx_cnt_d = div_q - 16'd1;
        if (tx_bit == 3'd7) begin
          tx_d  = TX_STOP;
          txd_d = 1'b1;
        end else begin
          tx_bit_d = tx_bit + 3'd1;
          tx_sh_d  = {1'b0, tx_sh[7:1]};
          txd_d    = tx_sh[1];
        end
      end
      TX_STOP: if (tx_cnt == 16'd0) begin
        if (hold_full) begin
          take_hold = 1'b1;
          tx_d      = TX_START;
          tx_sh_d   = hold_q;
          txd_d     = 1'b0;
          tx_cnt_d  = div_q - 16'd1;
        end else begin
          tx_d = TX_IDLE;
        end
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st  <= TX_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
      txd_q  <= 1'b1;
    end else begin
      tx_st  <= tx_d;
      tx_cnt <= tx_cnt_d;
      tx_bit <= tx_bit_d;
      tx_sh  <= tx_sh_d;
      txd_q  <= txd_d;
    end
  end

  // ---------------- RX ----------------
  rx_state_t   rx_st, rx_d;
  logic [15:0] rx_cnt, rx_cnt_d;
  logic [2:0]  rx_bit, rx_bit_d;
  logic [7:0]  rx_sh, rx_sh_d;
  logic        rx_s1, rx_s2, rx_prev;
  logic        deliver, frm_set;

  always_comb begin
    rx_d     = rx_st;
    rx_cnt_d = rx_cnt;
    rx_bit_d = rx_bit;
    rx_sh_d  = rx_sh;
    deliver  = 1'b0;
    frm_set  = 1'b0;
    if (rx_st != RX_IDLE && rx_cnt != 16'd0)
      rx_cnt_d = rx_cnt - 16'd1;
    unique case (rx_st)
      RX_IDLE: if (rx_prev & ~rx_s2) begin
        rx_d     = RX_START;
        rx_cnt_d = {1'b0, div_q[15:1]} - 16'd1;
      end
      RX_START: if (rx_cnt == 16'd0) begin
        if (rx_s2) begin
          rx_d = RX_IDLE;
        end else begin
          rx_d     = RX_DATA;
          rx_bit_d = 3'd0;
          rx_cnt_d = div_q - 16'd1;
        end
      end
      RX_DATA: if (rx_cnt == 16'd0) begin
        rx_sh_d  = {rx_s2, rx_sh[7:1]};
        rx_cnt_d = div_q - 16'd1;
        if (rx_bit == 3'd7) rx_d = RX_STOP;
        else rx_bit_d = rx_bit + 3'd1;
      end
      RX_STOP: if (rx_cnt == 16'd0) begin
        rx_d    = RX_IDLE;
        deliver = rx_s2;
        frm_set = ~rx_s2;
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st   <= RX_IDLE;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_st   <= rx_d;
      rx_cnt  <= rx_cnt_d;
      rx_bit  <= rx_bit_d;
      rx_sh   <= rx_sh_d;
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // ---------------- RX storage ----------------
  logic       rx_valid, pop, ovr_set, rd_data;
  logic [7:0] rx_byte;

  assign rd_data = rd & (sel == REG_DATA);
  assign pop     = rd_data & rx_valid;
  assign irq     = rx_valid;

`ifdef WB_UART_RX_FIFO_EN
  logic fifo_empty, fifo_full, push;

  assign rx_valid = ~fifo_empty;
  assign push     = deliver & (~fifo_full | pop);
  assign ovr_set  = deliver & fifo_full & ~pop;

  wb_uart_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (rx_sh),
    .dout  (rx_byte),
    .empty (fifo_empty),
    .full  (fifo_full)
  );
`else
  logic        rx_full_q;
  logic [7:0]  rx_data_q;
  logic [31:0] unused_depth;

  assign unused_depth = RX_DEPTH;
  assign rx_valid     = rx_full_q;
  assign rx_byte      = rx_data_q;
  // a pop in the delivery cycle makes room, so no overrun
  assign ovr_set      = deliver & rx_full_q & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_full_q <= 1'b0;
      rx_data_q <= '0;
    end else if (deliver) begin
      rx_full_q <= 1'b1;
      rx_data_q <= rx_sh;
    end else if (pop) begin
      rx_full_q <= 1'b0;
    end
  end
`endif

  // ---------------- registers / bus ----------------
  logic rx_ovr, frm_err, stat_rd;

  assign stat_rd = rd & (sel == REG_STAT);

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (sel == REG_DATA): rdata = rx_valid ? {8'h00, rx_byte} : 16'h0;
      (sel == REG_STAT): begin
        rdata[STAT_RXV] = rx_valid;
        rdata[STAT_TXR] = tx_ready;
        rdata[STAT_TXB] = tx_busy;
        rdata[STAT_OVR] = rx_ovr;
        rdata[STAT_FRM] = frm_err;
      end
      (sel == REG_DIV):  rdata = div_q;
      (sel == REG_RSVD): rdata = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      div_q     <= DIV_RESET;
      hold_q    <= '0;
      hold_full <= 1'b0;
      rx_ovr    <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      ack_q   <= acc;
      dat_q   <= rd ? rdata : 16'h0;
      // a set event wins over the clearing read
      rx_ovr  <= (rx_ovr & ~stat_rd) | ovr_set;
      frm_err <= (frm_err & ~stat_rd) | frm_set;
      if (wr && sel == REG_DIV)
        div_q <= (wb.dat_i < 16'd2) ? 16'd2 : wb.dat_i;
      if (tx_wr) begin
        hold_q    <= wb.dat_i[7:0];
        hold_full <= 1'b1;
      end else if (take_hold) begin
        hold_full <= 1'b0;
      end
    end
  end
endmodule
